// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, FSM states and
// flag-register bit positions.
package alu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_STORE   = 3'b001;
    localparam int         OP_ALU_MSB = 2;

    localparam int FLG_CO  = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_N   = 1;
    localparam int FLG_Z   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } seq_state_e;

    // ALU opcodes carry the ALU control in their low bits
    function automatic logic is_alu_op(input logic [2:0] op);
        return op[OP_ALU_MSB];
    endfunction

endpackage

// File: rtl/alu_acc_sequencer.sv
// Accumulator command sequencer driving a combinational ALU from registers.
// Optional ALU_ACC_STICKY_OVF_EN adds a sticky overflow output.
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_ctrl,
    input  logic [W-1:0] alu_out,
    input  logic         alu_co,
    input  logic         alu_ovf,
    input  logic         alu_n,
    input  logic         alu_z,
`ifdef ALU_ACC_STICKY_OVF_EN
    output logic         sticky_ovf,
`endif
    output logic [W-1:0] acc_out
);

    seq_state_e   state_r;
    logic [W-1:0] acc_r;
    logic [3:0]   flags_r;
    logic [W-1:0] alu_a_r;
    logic [W-1:0] alu_b_r;
    logic [1:0]   alu_ctrl_r;
    logic         cmd_ready_r;
    logic         rsp_valid_r;

    logic         accept_s;
    logic         load_accept_s;
    logic [3:0]   load_flags_s;
    logic [3:0]   exec_flags_s;

    // Accept decode and the two sources of the flag register
    always_comb begin
        accept_s      = cmd_valid & cmd_ready_r;
        load_accept_s = accept_s & (cmd_op == OP_LOAD);
        load_flags_s  = 4'b0000;
        load_flags_s[FLG_N] = cmd_data[W-1];
        load_flags_s[FLG_Z] = (cmd_data == {W{1'b0}});
        exec_flags_s  = 4'b0000;
        exec_flags_s[FLG_CO]  = alu_co;
        exec_flags_s[FLG_OVF] = alu_ovf;
        exec_flags_s[FLG_N]   = alu_n;
        exec_flags_s[FLG_Z]   = alu_z;
    end

    // Command FSM; cmd_ready_r and rsp_valid_r track IDLE and RESP exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {W{1'b0}};
            flags_r     <= 4'b0000;
            alu_a_r     <= {W{1'b0}};
            alu_b_r     <= {W{1'b0}};
            alu_ctrl_r  <= 2'b00;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        if (is_alu_op(cmd_op)) begin
                            alu_a_r    <= acc_r;
                            alu_b_r    <= cmd_data;
                            alu_ctrl_r <= cmd_op[1:0];
                            state_r    <= EXEC;
                        end else if (load_accept_s) begin
                            acc_r       <= cmd_data;
                            flags_r     <= load_flags_s;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            // STORE and reserved opcodes just report ACC
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    acc_r       <= alu_out;
                    flags_r     <= exec_flags_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ACC_STICKY_OVF_EN
    logic sticky_ovf_r;

    // Overflow history: set by an overflowing ALU op, cleared only by LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_r <= 1'b0;
        end else if ((state_r == EXEC) && alu_ovf) begin
            sticky_ovf_r <= 1'b1;
        end else if (load_accept_s) begin
            sticky_ovf_r <= 1'b0;
        end else begin
            sticky_ovf_r <= sticky_ovf_r;
        end
    end

    assign sticky_ovf = sticky_ovf_r;
`endif

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = acc_r;
    assign rsp_flags = flags_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_ctrl  = alu_ctrl_r;
    assign acc_out   = acc_r;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Scoreboard bench for alu_acc_sequencer with a behavioural ALU attached
// (ctrl 00 AND, 01 OR, 10 ADD, 11 SUB).
module tb_alu_acc_sequencer;
    import alu_pkg::*;

    localparam int W = 12;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_out;
    logic         alu_co, alu_ovf, alu_n, alu_z;
    logic [W-1:0] acc_out;
`ifdef ALU_ACC_STICKY_OVF_EN
    logic         sticky_ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   flags;
    } rsp_t;
    rsp_t exp_q[$];

    alu_acc_sequencer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf),
        .alu_n(alu_n), .alu_z(alu_z),
`ifdef ALU_ACC_STICKY_OVF_EN
        .sticky_ovf(sticky_ovf),
`endif
        .acc_out(acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream combinational ALU
    always_comb begin
        logic [W:0] sum;
        sum     = '0;
        alu_co  = 1'b0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            2'b00: alu_out = alu_a & alu_b;
            2'b01: alu_out = alu_a | alu_b;
            2'b10: begin
                sum     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = sum[W-1:0];
                alu_co  = sum[W];
                alu_ovf = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            default: begin
                sum     = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
                alu_out = sum[W-1:0];
                alu_co  = sum[W];
                alu_ovf = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
        endcase
        alu_n = alu_out[W-1];
        alu_z = (alu_out == {W{1'b0}});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data 0x%0h flags 0x%0h, expected none",
                         rsp_data, rsp_flags);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e.data || rsp_flags !== e.flags) begin
                    errors++;
                    $display("FAIL rsp: got data 0x%0h flags 0x%0h, expected data 0x%0h flags 0x%0h",
                             rsp_data, rsp_flags, e.data, e.flags);
                end
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data,
                           input logic [W-1:0] exp_data, input logic [3:0] exp_flags,
                           input int exp_lat, input int hold);
        rsp_t e;
        int   lat;
        bit   seen;
        logic [W-1:0] acc_before;
        @(negedge clk);
        acc_before = acc_out;
        rsp_ready  = (hold == 0);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = data;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        e.data  = exp_data;
        e.flags = exp_flags;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 12'hA5A;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (k == 0 && op[2]) begin
                chk("exec_alu_a", {20'd0, alu_a}, {20'd0, acc_before});
                chk("exec_alu_b", {20'd0, alu_b}, {20'd0, data});
                chk("exec_alu_ctrl", {30'd0, alu_ctrl}, {30'd0, op[1:0]});
            end
            lat++;
        end
        if (!seen) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_LOAD;
                cmd_data  = 12'h123;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {20'd0, rsp_data}, {20'd0, exp_data});
            chk("bp_rsp_flags", {28'd0, rsp_flags}, {28'd0, exp_flags});
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_acc", {20'd0, acc_out}, {20'd0, exp_data});
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {20'd0, rsp_data}, 32'd0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        chk("rst_alu_regs", {18'd0, alu_ctrl, alu_a}, 32'd0);
        chk("rst_alu_b", {20'd0, alu_b}, 32'd0);
        chk("rst_acc", {20'd0, acc_out}, 32'd0);
        rst_n = 1'b1;

        //       op      data     exp_data exp_flags lat hold
        run_cmd(3'b000, 12'h7FF, 12'h7FF, 4'b0000, 1, 0);
        run_cmd(3'b110, 12'h001, 12'h800, 4'b0110, 2, 0);
        run_cmd(3'b000, 12'hFFF, 12'hFFF, 4'b0010, 1, 0);
        run_cmd(3'b110, 12'h001, 12'h000, 4'b1001, 2, 0);
        run_cmd(3'b001, 12'h555, 12'h000, 4'b1001, 1, 0);
        run_cmd(3'b010, 12'hABC, 12'h000, 4'b1001, 1, 0);
        run_cmd(3'b000, 12'h005, 12'h005, 4'b0000, 1, 0);
        run_cmd(3'b111, 12'h007, 12'hFFE, 4'b0010, 2, 0);
        run_cmd(3'b100, 12'h0F0, 12'h0F0, 4'b0000, 2, 0);
        run_cmd(3'b101, 12'h00F, 12'h0FF, 4'b0000, 2, 0);
        run_cmd(3'b001, 12'h000, 12'h0FF, 4'b0000, 1, 5);
        run_cmd(3'b111, 12'h0FF, 12'h000, 4'b1001, 2, 0);

        run_cmd(3'b000, 12'h7FF, 12'h7FF, 4'b0000, 1, 0);
`ifdef ALU_ACC_STICKY_OVF_EN
        chk("sticky_after_load", {31'd0, sticky_ovf}, 32'd0);
`endif
        run_cmd(3'b110, 12'h001, 12'h800, 4'b0110, 2, 0);
`ifdef ALU_ACC_STICKY_OVF_EN
        chk("sticky_set", {31'd0, sticky_ovf}, 32'd1);
`endif
        run_cmd(3'b110, 12'h001, 12'h801, 4'b0010, 2, 0);
`ifdef ALU_ACC_STICKY_OVF_EN
        chk("sticky_hold", {31'd0, sticky_ovf}, 32'd1);
`endif
        run_cmd(3'b000, 12'h000, 12'h000, 4'b0001, 1, 0);
`ifdef ALU_ACC_STICKY_OVF_EN
        chk("sticky_clear", {31'd0, sticky_ovf}, 32'd0);
`endif

        // Asynchronous reset in the middle of an add
        run_cmd(3'b000, 12'h7FF, 12'h7FF, 4'b0000, 1, 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'b110;
        cmd_data  = 12'h001;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_exec_alu_a", {20'd0, alu_a}, 32'h7FF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acc", {20'd0, acc_out}, 32'd0);
        chk("arst_flags", {28'd0, rsp_flags}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_cmd(3'b001, 12'h3C3, 12'h000, 4'b0000, 1, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Accumulator-based command sequencer sitting directly upstream of the combinational ALU (12-bit default).
- Accepts commands over a valid/ready handshake and holds the running accumulator (ACC).
- Drives the ALU operand and control inputs from registers, then captures the ALU result and flags back into ACC and a flag register.
- Returns each result on a valid/ready response channel.

Parameters:
- W, 12: datapath width; must match the downstream ALU W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 LOAD, 001 STORE, 01x reserved (treated as STORE), 1cc ALU op with ALU control = cc.
- cmd_data  in  W  operand (B for ALU ops, value for LOAD; ignored for STORE).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  ACC value after the command.
- rsp_flags  out  4  {CO, OVF, N, Z} flag register after the command.
- alu_a  out  W  registered ALU DATA_A (= ACC).
- alu_b  out  W  registered ALU DATA_B (= cmd_data).
- alu_ctrl  out  2  registered ALU control.
- alu_out  in  W  ALU OUT.
- alu_co, alu_ovf, alu_n, alu_z  in  1 each  ALU flags.
- acc_out  out  W  live ACC value.

Behaviour:
- Reset:
  - State is IDLE.
  - ACC, flags, alu_a, alu_b, alu_ctrl, rsp_data and rsp_flags are all 0.
  - rsp_valid is 0; cmd_ready is 1.
  - Reset is asynchronous at any point and aborts any in-flight command with no response.
- FSM states: IDLE, EXEC, RESP.
- cmd_ready is high only in IDLE. A command is accepted on a clock edge with cmd_valid & cmd_ready.
- IDLE, ALU op accepted:
  - Register alu_a <= ACC, alu_b <= cmd_data, alu_ctrl <= cmd_op[1:0].
  - Go to EXEC.
- EXEC (exactly one cycle):
  - ALU outputs are combinationally valid.
  - On the closing edge: ACC <= alu_out, flags <= {alu_co, alu_ovf, alu_n, alu_z}.
  - Go to RESP.
- IDLE, LOAD accepted:
  - ACC <= cmd_data.
  - flags <= {0, 0, cmd_data[W-1], cmd_data==0}.
  - Go directly to RESP.
- IDLE, STORE or reserved op accepted:
  - No change to ACC or flags.
  - Go directly to RESP.
- RESP:
  - rsp_valid = 1; rsp_data = ACC; rsp_flags = flag register.
  - Both values stay stable while rsp_valid & !rsp_ready.
  - On rsp_ready, go to IDLE.
  - No command is accepted in the same cycle as the response handshake.
- Latency, counted from the accept edge N:
  - ALU op: rsp_valid is high from the cycle after edge N+1 (two edges).
  - LOAD/STORE: rsp_valid is high from the cycle after edge N (one edge).
- alu_a, alu_b and alu_ctrl hold their last values outside EXEC. Downstream ALU outputs are don't-care outside EXEC.
- Arithmetic wraps modulo 2^W (the ALU's behaviour). The sequencer performs no width extension.
- cmd_valid while busy: ignored. cmd_data and cmd_op may change freely when not accepted.
- rsp_ready while rsp_valid=0: ignored.

Optional Feature:
- Macro: ALU_ACC_STICKY_OVF_EN.
- Defined:
  - Adds output port sticky_ovf (1 bit, reset 0).
  - sticky_ovf is set on the EXEC closing edge when alu_ovf=1.
  - A LOAD clears it. It is otherwise held across commands.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_LOAD=3'b000, OP_STORE=3'b001, OP_ALU_MSB=2.
  - FSM state enum (IDLE, EXEC, RESP).
  - flag bit index constants FLG_CO=3, FLG_OVF=2, FLG_N=1, FLG_Z=0.
- No sub-module is needed. The bench instantiates alu_acc_sequencer wired to the ALU as DUT.

Test Plan:
- W=12: LOAD 0x7FF, then ALU op 110 (add) with data 0x001 -> rsp_data 0x800, flags {CO=0, OVF=1, N=1, Z=0}; rsp_valid 2 edges after accept.
- LOAD 0xFFF, then add 0x001 -> rsp_data 0x000, flags {CO=1, OVF=0, N=0, Z=1}. Then STORE -> same data and flags, rsp_valid 1 edge after accept.
- LOAD 0x005, then ALU op 111 (sub) with 0x007 -> rsp_data 0xFFE, N=1, Z=0. Then ALU op 100 with 0x0F0 -> logic result per ALU control 00, CO=0, OVF=0.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_flags stable; cmd_ready=0.
  - A cmd_valid pulse in that window is not accepted.
  - After rsp_ready, cmd_ready returns 1 next cycle.
- Assert rst_n=0 mid-EXEC of an add -> ACC=0, flags=0, rsp_valid=0, cmd_ready=1 immediately (asynchronous); no response emitted after release.
- With ALU_ACC_STICKY_OVF_EN:
  - Overflowing add sets sticky_ovf=1.
  - A subsequent non-overflowing add leaves it at 1.
  - LOAD 0x000 clears it to 0.
